vram_console: RTL

Write-side companion to the VGA text display: accepts a stream of console commands over a valid/ready handshake and writes 3-bit colour cells into the video cell memory that the display path reads (80×60 cells of 8×8 pixels, linear address col + row·80). It keeps a cursor, handles column and row wrap, newline and cursor positioning, and performs a full-screen fill without CPU involvement. It sits between a command source (CPU/UART bridge) and the write port of the dual-port cell memory.

---
 rtl/vram_console.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vram_console.sv
`default_nettype none
// ============================================================================
//  Module   : vram_console
//  Purpose  : Console command engine writing colour cells into the video
//             cell memory (PUT / NEWLINE / GOTO / CLEAR full-screen fill).
//  Revision : 1.0  initial release
// ============================================================================
module vram_console #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int AW   = 13,
    parameter int DW   = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [12:0]   cmd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic [6:0]    cur_col,
    output logic [5:0]    cur_row
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [1:0] OP_PUT     = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_GOTO    = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [6:0]    c_cols      = 7'(COLS);
    localparam logic [5:0]    c_rows      = 6'(ROWS);
    localparam logic [6:0]    c_last_col  = 7'(COLS - 1);
    localparam logic [5:0]    c_last_row  = 6'(ROWS - 1);
    localparam logic [AW-1:0] c_last_addr = AW'(COLS * ROWS - 1);

    logic [0:0]    state_q, state_d;
    logic [6:0]    col_q, col_d;
    logic [5:0]    row_q, row_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          w_accept;
    logic          w_fill_done;
    logic [AW-1:0] w_cur_addr;

    assign w_accept    = cmd_valid && (state_q == S_IDLE);
    assign w_fill_done = (state_q == S_FILL) && (wr_addr_q == c_last_addr);
    assign w_cur_addr  = AW'(row_q) * AW'(COLS) + AW'(col_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept && (cmd_op == OP_CLEAR)) state_d = S_FILL;
            S_FILL:  if (w_fill_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q == S_FILL);
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_q == S_FILL) begin
            // wr_addr doubles as the fill counter; the last write ends the fill
            if (!w_fill_done) begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end else if (w_accept) begin
            case (cmd_op)
                OP_PUT: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = w_cur_addr;
                    wr_data_d = cmd_data[DW-1:0];
                    if (col_q == c_last_col) begin
                        col_d = '0;
                        row_d = (row_q == c_last_row) ? '0 : row_q + 6'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
                OP_NEWLINE: begin
                    col_d = '0;
                    row_d = (row_q == c_last_row) ? '0 : row_q + 6'd1;
                end
                OP_GOTO: begin
                    if ((cmd_data[6:0] < c_cols) && (cmd_data[12:7] < c_rows)) begin
                        col_d = cmd_data[6:0];
                        row_d = cmd_data[12:7];
                    end
                end
                OP_CLEAR: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = cmd_data[DW-1:0];
                    col_d     = '0;
                    row_d     = '0;
                end
                default: ;
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cur_col = col_q;
    assign cur_row = row_q;

endmodule
`default_nettype wire
